// File: rtl/fluid_pkg.sv
// rtl/fluid_pkg.sv - shared field geometry, sweep state encoding and width helper
package fluid_pkg;

  localparam int FIELD_WIDTH  = 8;
  localparam int FIELD_HEIGHT = 6;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_RV,
    EMIT,
    ADVANCE,
    FINISH
  } sweep_state_t;

  function automatic int coord_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rb_cursor.sv
// rtl/rb_cursor.sv - red-black cell cursor: parity 0 cells then parity 1, row-major, x by 2
module rb_cursor
  import fluid_pkg::*;
#(
  parameter int W  = FIELD_WIDTH,
  parameter int H  = FIELD_HEIGHT,
  parameter int XW = coord_w(FIELD_WIDTH),
  parameter int YW = coord_w(FIELD_HEIGHT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          step,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic          parity_last,
  output logic          iter_last
);

  logic parity;
  logic row_last;
  logic col_last;
  logic next_row_odd;

  assign row_last     = (int'(x) + 2) >= W;
  assign col_last     = int'(y) == (H - 1);
  assign parity_last  = row_last && col_last;
  assign iter_last    = parity_last && parity;
  // First x of the next row keeps (x + y + parity) even/odd as required
  assign next_row_odd = ~(y[0] ^ parity);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x      <= '0;
      y      <= '0;
      parity <= 1'b0;
    end else if (clear) begin
      x      <= '0;
      y      <= '0;
      parity <= 1'b0;
    end else if (step) begin
      if (!row_last) begin
        x <= x + XW'(2);
      end else if (!col_last) begin
        y <= y + YW'(1);
        x <= XW'(next_row_odd);
      end else if (!parity) begin
        parity <= 1'b1;
        y      <= '0;
        x      <= XW'(1);
      end else begin
        parity <= 1'b0;
        y      <= '0;
        x      <= '0;
      end
    end
  end

endmodule

// File: rtl/sweep_ctrl.sv
// rtl/sweep_ctrl.sv - red-black sweep sequencer between velocity reader and solver
module sweep_ctrl
  import fluid_pkg::*;
#(
  parameter int FIELD_WIDTH  = fluid_pkg::FIELD_WIDTH,
  parameter int FIELD_HEIGHT = fluid_pkg::FIELD_HEIGHT,
  parameter int ITER_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              go,
  input  logic [ITER_W-1:0] num_iters,
  input  logic              abort,
  output logic [31:0]       field_x,
  output logic [31:0]       field_y,
  output logic              rv_start,
  input  logic              rv_done,
  input  logic [2:0]        rv_n,
  output logic              cell_valid,
  input  logic              cell_ready,
  output logic [31:0]       cell_x,
  output logic [31:0]       cell_y,
  output logic [2:0]        cell_n,
  output logic              busy,
  output logic              iter_done,
  output logic              sweep_done
);

  localparam int XW = coord_w(FIELD_WIDTH);
  localparam int YW = coord_w(FIELD_HEIGHT);

  sweep_state_t      state;
  sweep_state_t      nxt;
  logic [ITER_W-1:0] iter_cnt;
  logic [2:0]        n_q;
  logic [XW-1:0]     cur_x;
  logic [YW-1:0]     cur_y;
  logic              parity_last;
  logic              iter_last;
  logic              iter_end;
  logic              cur_clear;
  logic              cur_step;
  logic              aborting;

  rb_cursor #(
    .W  (FIELD_WIDTH),
    .H  (FIELD_HEIGHT),
    .XW (XW),
    .YW (YW)
  ) u_cursor (
    .clk         (clk),
    .rst         (rst),
    .clear       (cur_clear),
    .step        (cur_step),
    .x           (cur_x),
    .y           (cur_y),
    .parity_last (parity_last),
    .iter_last   (iter_last)
  );

  assign iter_end = iter_last && parity_last;
  assign aborting = abort && (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      iter_cnt <= '0;
      n_q      <= '0;
    end else begin
      if (aborting) begin
        iter_cnt <= '0;
      end else if (state == IDLE && go) begin
        iter_cnt <= num_iters;
      end else if (state == ADVANCE && iter_end && iter_cnt != '0) begin
        iter_cnt <= iter_cnt - ITER_W'(1);
      end
      if (!aborting && state == WAIT_RV && rv_done) begin
        n_q <= rv_n;
      end
    end
  end

  always_comb begin
    nxt        = state;
    rv_start   = 1'b0;
    cell_valid = 1'b0;
    iter_done  = 1'b0;
    sweep_done = 1'b0;
    cur_clear  = 1'b0;
    cur_step   = 1'b0;
    case (state)
      IDLE: begin
        if (go) begin
          if (num_iters != '0) begin
            cur_clear = 1'b1;
            nxt       = ISSUE;
          end else begin
            nxt = FINISH;
          end
        end
      end
      ISSUE: begin
        rv_start = 1'b1;
        nxt      = WAIT_RV;
      end
      WAIT_RV: begin
        if (rv_done) begin
          nxt = (rv_n != 3'd0) ? EMIT : ADVANCE;
        end
      end
      EMIT: begin
        cell_valid = 1'b1;
        if (cell_ready) begin
          nxt = ADVANCE;
        end
      end
      ADVANCE: begin
        cur_step = 1'b1;
        if (iter_end) begin
          iter_done = 1'b1;
          nxt       = (iter_cnt <= ITER_W'(1)) ? FINISH : ISSUE;
        end else begin
          nxt = ISSUE;
        end
      end
      FINISH: begin
        sweep_done = 1'b1;
        nxt        = IDLE;
      end
      default: nxt = IDLE;
    endcase
    // Abort wins over everything: no pulses, no cursor motion, straight to IDLE
    if (aborting) begin
      nxt        = IDLE;
      rv_start   = 1'b0;
      cell_valid = 1'b0;
      iter_done  = 1'b0;
      sweep_done = 1'b0;
      cur_step   = 1'b0;
    end
  end

  assign busy    = (state != IDLE);
  assign field_x = 32'(cur_x);
  assign field_y = 32'(cur_y);
  assign cell_x  = 32'(cur_x);
  assign cell_y  = 32'(cur_y);
  assign cell_n  = n_q;

endmodule

// File: tb/tb_sweep_ctrl.sv
// tb/tb_sweep_ctrl.sv - randomized directed bench for sweep_ctrl against a red-black order model
module tb_sweep_ctrl;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int IW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          go;
  logic [IW-1:0] num_iters;
  logic          abort;
  logic [31:0]   field_x, field_y, cell_x, cell_y;
  logic          rv_start, rv_done, cell_valid, cell_ready;
  logic [2:0]    rv_n, cell_n;
  logic          busy, iter_done, sweep_done;

  int     vectors = 0;
  int     miscompares = 0;
  int     n_tab [W][H];
  longint got [$];
  longint exp_q [$];
  int     n_rvstart, n_iter, n_sweep, pend;
  logic [31:0] px, py;
  bit     resp_en, ready_auto, ready_rand;

  always #5 clk = ~clk;

  sweep_ctrl #(
    .FIELD_WIDTH  (W),
    .FIELD_HEIGHT (H),
    .ITER_W       (IW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .num_iters  (num_iters),
    .abort      (abort),
    .field_x    (field_x),
    .field_y    (field_y),
    .rv_start   (rv_start),
    .rv_done    (rv_done),
    .rv_n       (rv_n),
    .cell_valid (cell_valid),
    .cell_ready (cell_ready),
    .cell_x     (cell_x),
    .cell_y     (cell_y),
    .cell_n     (cell_n),
    .busy       (busy),
    .iter_done  (iter_done),
    .sweep_done (sweep_done)
  );

  function automatic longint key(input longint x, input longint y, input longint n);
    return x * 10000 + y * 100 + n;
  endfunction

  task automatic check(input string tag, input longint obs, input longint expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference order: per iteration, every (x+y)-even cell row-major, then every odd one
  task automatic build_exp(input int iters);
    exp_q.delete();
    for (int it = 0; it < iters; it++)
      for (int p = 0; p < 2; p++)
        for (int y = 0; y < H; y++)
          for (int x = 0; x < W; x++)
            if (((x + y) % 2) == p && n_tab[x][y] != 0)
              exp_q.push_back(key(x, y, n_tab[x][y]));
  endtask

  task automatic fill_tab(input int mode);
    for (int x = 0; x < W; x++)
      for (int y = 0; y < H; y++)
        n_tab[x][y] = (mode < 0) ? $urandom_range(0, 4) : mode;
  endtask

  task automatic clear_counts();
    got.delete();
    n_rvstart = 0;
    n_iter    = 0;
    n_sweep   = 0;
  endtask

  task automatic wait_sweep(input string tag);
    int c;
    c = 0;
    while (n_sweep == 0 && c < 8000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_sweep_done"}, n_sweep, 1);
  endtask

  task automatic do_sweep(input int iters, input string tag);
    int bad;
    clear_counts();
    build_exp(iters);
    num_iters = IW'(iters);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    wait_sweep(tag);
    @(negedge clk);
    check({tag, "_cells"}, got.size(), exp_q.size());
    bad = -1;
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      if (bad < 0 && got[i] != exp_q[i]) bad = i;
    check({tag, "_order_first_bad"}, bad, -1);
    check({tag, "_iter_done"}, n_iter, iters);
    check({tag, "_rv_starts"}, n_rvstart, W * H * iters);
    check({tag, "_idle"}, busy, 0);
  endtask

  // Velocity-reader / solver stand-in and event monitor, all on the falling edge
  initial forever begin
    @(negedge clk);
    if (rst) pend = 0;
    if (resp_en) begin
      rv_done = 1'b0;
      rv_n    = 3'($urandom_range(0, 7));
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          rv_done = 1'b1;
          rv_n    = (px < W && py < H) ? 3'(n_tab[px][py]) : 3'd0;
        end
      end
    end
    if (ready_auto) cell_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    if (!rst) begin
      if (rv_start) begin
        n_rvstart++;
        if (resp_en) begin
          pend = $urandom_range(1, 3);
          px   = field_x;
          py   = field_y;
        end
      end
      if (cell_valid && cell_ready) got.push_back(key(cell_x, cell_y, cell_n));
      if (iter_done) n_iter++;
      if (sweep_done) n_sweep++;
    end
  end

  initial begin
    int c;
    rst = 1'b1; go = 1'b0; abort = 1'b0; rv_done = 1'b0; rv_n = 3'd0;
    cell_ready = 1'b0; num_iters = '0;
    resp_en = 1'b0; ready_auto = 1'b0; ready_rand = 1'b0; pend = 0;
    clear_counts();
    repeat (3) @(negedge clk);

    check("rst_busy", busy, 0);
    check("rst_rv_start", rv_start, 0);
    check("rst_cell_valid", cell_valid, 0);
    check("rst_pulses", {iter_done, sweep_done}, 0);
    check("rst_coords", field_x | field_y | cell_x | cell_y, 0);
    check("rst_cell_n", cell_n, 0);
    rst = 1'b0;
    @(negedge clk);

    // Full 8x6 single iteration, every cell open on all faces
    fill_tab(4); resp_en = 1'b1; ready_auto = 1'b1; ready_rand = 1'b0;
    do_sweep(1, "full");
    check("full_cell1", (got.size() > 24) ? got[1] : -1, key(2, 0, 4));
    check("full_cell4", (got.size() > 24) ? got[4] : -1, key(1, 1, 4));
    check("full_cell24", (got.size() > 24) ? got[24] : -1, key(1, 0, 4));

    // Closed cell at (2,0) is never offered
    fill_tab(4); n_tab[2][0] = 0;
    do_sweep(1, "skip20");

    // Solver back-pressure at the first cell
    fill_tab(4); ready_auto = 1'b0; cell_ready = 1'b0;
    clear_counts();
    num_iters = IW'(1); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    c = 0;
    while (!cell_valid && c < 20) begin @(negedge clk); c++; end
    for (int k = 0; k < 5; k++) begin
      check("stall_valid", cell_valid, 1);
      check("stall_cell", key(cell_x, cell_y, cell_n), key(0, 0, 4));
      check("stall_rv_starts", n_rvstart, 1);
      @(negedge clk);
    end
    ready_auto = 1'b1;
    wait_sweep("stall");
    check("stall_cells", got.size(), W * H);

    // Zero iterations: straight to FINISH, no reader traffic
    repeat (2) @(negedge clk);
    clear_counts();
    num_iters = '0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check("zero_sweep_done", sweep_done, 1);
    check("zero_busy", busy, 1);
    @(negedge clk);
    check("zero_back_idle", {busy, sweep_done}, 0);
    check("zero_rv_starts", n_rvstart, 0);
    check("zero_pulses", n_sweep, 1);

    // Randomized closed cells, solver stalls and multiple iterations
    for (int r = 0; r < 3; r++) begin
      fill_tab(-1); ready_rand = 1'b1;
      do_sweep($urandom_range(2, 3), $sformatf("rand%0d", r));
    end

    // Abort at the 30th cell of a 3-iteration sweep
    fill_tab(4); ready_rand = 1'b0;
    clear_counts();
    num_iters = IW'(3); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    c = 0;
    while (got.size() < 30 && c < 2000) begin @(negedge clk); c++; end
    check("abort_reached30", got.size() >= 30, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_cell_valid", cell_valid, 0);
    repeat (5) @(negedge clk);
    check("abort_no_sweep_done", n_sweep, 0);
    check("abort_no_iter_done", n_iter, 0);
    check("abort_stays_idle", busy, 0);
    do_sweep(1, "after_abort");

    // Reset while waiting on the reader at cell (4,0); late completion ignored
    resp_en = 1'b0; rv_done = 1'b0;
    clear_counts();
    num_iters = IW'(1); go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    for (int k = 0; k < 3; k++) begin
      c = 0;
      while (!rv_start && c < 50) begin @(negedge clk); c++; end
      check("rstw_rv_start_seen", rv_start, 1);
      @(negedge clk);
      if (k < 2) begin
        rv_done = 1'b1; rv_n = 3'd4;
        @(negedge clk);
        rv_done = 1'b0;
      end
    end
    check("rstw_field_x", field_x, 4);
    check("rstw_busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    check("rstw_busy0", busy, 0);
    check("rstw_coords0", field_x | field_y | cell_x | cell_y, 0);
    check("rstw_outs0", {cell_n, cell_valid, rv_start, iter_done, sweep_done}, 0);
    @(negedge clk);
    rst = 1'b0; rv_done = 1'b1; rv_n = 3'd4;
    @(negedge clk);
    rv_done = 1'b0;
    check("rstw_late_idle", {busy, cell_valid}, 0);
    repeat (3) @(negedge clk);
    check("rstw_still_idle", busy, 0);
    check("rstw_rv_starts", n_rvstart, 3);
    resp_en = 1'b1;
    do_sweep(1, "after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
